// File: rtl/mem_bram_slave.sv
// Burst slave in front of a 2^ADDR_BITS x 16 block RAM with a request/ready handshake.
// Optional define MEM_BRAM_SLAVE_STATS_EN adds saturating busy/idle cycle counters.
module mem_bram_slave #(
  parameter int ADDR_BITS    = 12,
  parameter int ACCEPT_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic        write_enable,
  input  logic [21:0] address,
  input  logic        last4,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  output logic        ready
`ifdef MEM_BRAM_SLAVE_STATS_EN
  ,
  output logic [15:0] stat_work,
  output logic [15:0] stat_idle
`endif
);

  // state | meaning
  // IDLE  | no burst; request latches address and direction
  // WAIT  | accept delay running, ready low
  // READ  | read burst, ready high
  // WRITE | write burst, ready high
  typedef enum logic [1:0] {IDLE, WAIT, READ, WRITE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(ACCEPT_DELAY - 1);

  logic [15:0]          mem [0:(1 << ADDR_BITS) - 1];
  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] ptr, wr_addr, rd_addr;
  logic                 dir;
  logic [3:0]           wait_cnt;
  logic                 l4_armed;
  logic [1:0]           l4_cnt;
  logic                 wr_pend;
  logic                 xfer;
  logic                 rd_load;
  logic                 ptr_last;
  logic                 l4_end;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^address[21:ADDR_BITS];
  assign ptr_last       = &ptr;
  assign l4_end         = l4_armed && (l4_cnt == 2'd1);

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    case (state)
      IDLE: if (request) state_nxt = WAIT;
      WAIT: begin
        if (!request)               state_nxt = IDLE;
        else if (wait_cnt == 4'd0)  state_nxt = dir ? WRITE : READ;
      end
      READ, WRITE: begin
        if (!request) begin
          state_nxt = IDLE;
        end else begin
          xfer = 1'b1;
          // The address space ends the burst; no wrap to 0 inside a burst.
          if (ptr_last || ((state == READ) && l4_end)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prefetch: the word for the next read cycle is fetched at the edge before it.
  assign rd_load = ((state == WAIT) && (state_nxt == READ)) || ((state == READ) && xfer);
  assign rd_addr = (state == WAIT) ? ptr : ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b0;
      ptr      <= '0;
      dir      <= 1'b0;
      wait_cnt <= 4'd0;
      l4_armed <= 1'b0;
      l4_cnt   <= 2'd0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
    end else begin
      state   <= state_nxt;
      ready   <= (state_nxt == READ) || (state_nxt == WRITE);
      wr_pend <= (state == WRITE) && xfer;
      wr_addr <= ptr;
      case (state)
        IDLE: if (request) begin
          ptr      <= address[ADDR_BITS-1:0];
          dir      <= write_enable;
          wait_cnt <= WAIT_LOAD;
        end
        WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        default: if (xfer) ptr <= ptr + 1'b1;
      endcase
      if (state_nxt == IDLE) begin
        l4_armed <= 1'b0;
        l4_cnt   <= 2'd0;
      end else if ((state == READ) && xfer) begin
        if (!l4_armed && last4) begin
          l4_armed <= 1'b1;
          l4_cnt   <= 2'd3;
        end else if (l4_armed) begin
          l4_cnt <= l4_cnt - 2'd1;
        end
      end
    end
  end

  // Write data trails its transfer cycle by one; reset in that cycle drops it.
  always_ff @(posedge clk) begin
    if (wr_pend && !reset) mem[wr_addr] <= data_write;
  end

  always_ff @(posedge clk) begin
    if (reset)        data_read <= 16'h0000;
    else if (rd_load) data_read <= mem[rd_addr];
  end

`ifdef MEM_BRAM_SLAVE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_work <= 16'h0000;
      stat_idle <= 16'h0000;
    end else begin
      if (ready && (stat_work != 16'hFFFF))           stat_work <= stat_work + 16'd1;
      if ((state == IDLE) && (stat_idle != 16'hFFFF)) stat_idle <= stat_idle + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bram_slave.sv
// Directed bench for mem_bram_slave (ADDR_BITS=12, ACCEPT_DELAY=3).
module tb_mem_bram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        request;
  logic        write_enable;
  logic [21:0] address;
  logic        last4;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic        ready;
`ifdef MEM_BRAM_SLAVE_STATS_EN
  logic [15:0] stat_work;
  logic [15:0] stat_idle;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [15:0] rd_q [0:15];
  int          got;
  int          lat;
  logic        seen;

  mem_bram_slave #(.ADDR_BITS(12), .ACCEPT_DELAY(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .request      (request),
    .write_enable (write_enable),
    .address      (address),
    .last4        (last4),
    .data_write   (data_write),
    .data_read    (data_read),
    .ready        (ready)
`ifdef MEM_BRAM_SLAVE_STATS_EN
    ,
    .stat_work    (stat_work),
    .stat_idle    (stat_idle)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    repeat (20) begin
      tick();
      n++;
      if (ready === 1'b1) break;
    end
    check("ready_rise", {31'd0, ready}, 32'd1);
  endtask

  task automatic write_burst(input logic [21:0] a, input int n, input logic [15:0] d0,
                             input logic [15:0] stp);
    int l;
    request = 1'b1; write_enable = 1'b1; address = a;
    wait_ready(l);
    for (int i = 0; i <= n; i++) begin
      request    = (i < n);
      data_write = (i > 0) ? d0 + 16'(int'(stp) * (i - 1)) : 16'h0000;
      tick();
    end
    request = 1'b0; write_enable = 1'b0;
    check("wr_end_ready", {31'd0, ready}, 32'd0);
  endtask

  task automatic read_burst(input logic [21:0] a, input int want, input int l4_at,
                            output int n, output int l);
    request = 1'b1; write_enable = 1'b0; address = a; last4 = 1'b0;
    wait_ready(l);
    n = 0;
    while ((ready === 1'b1) && (n < want)) begin
      last4   = (n >= l4_at);
      rd_q[n] = data_read;
      n++;
      tick();
    end
    request = 1'b0; last4 = 1'b0;
    if (ready === 1'b1) tick();
  endtask

  initial begin
    reset = 1'b1; request = 1'b0; write_enable = 1'b0; address = '0;
    last4 = 1'b0; data_write = '0;
    tick(); tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_data_read", {16'd0, data_read}, 32'h0);
    reset = 1'b0;
    repeat (10) tick();

`ifdef MEM_BRAM_SLAVE_STATS_EN
    read_burst(22'hFFB, 10, 99, got, lat);
    check("stat_words", got, 5);
    check("stat_work", {16'd0, stat_work}, 32'd5);
    check("stat_idle", {16'd0, stat_idle}, 32'd11);
`endif

    // Write burst, then read back with latency check; 0x13 must survive.
    write_burst(22'h013, 1, 16'hABCD, 16'h0000);
    write_burst(22'h010, 3, 16'h1111, 16'h1111);
    read_burst(22'h010, 4, 99, got, lat);
    check("rd_latency", lat, 4);
    check("rd_count", got, 4);
    check("rd_w0", {16'd0, rd_q[0]}, 32'h1111);
    check("rd_w1", {16'd0, rd_q[1]}, 32'h2222);
    check("rd_w2", {16'd0, rd_q[2]}, 32'h3333);
    check("rd_0x13_kept", {16'd0, rd_q[3]}, 32'hABCD);

    // Upper address bits alias.
    read_burst(22'h3FF010, 1, 99, got, lat);
    check("alias_w0", {16'd0, rd_q[0]}, 32'h1111);

    // End of address space: slave stops after word 0xFFF.
    write_burst(22'hFFE, 2, 16'h5A5A, 16'h4B4B);
    read_burst(22'hFFE, 10, 99, got, lat);
    check("eos_count", got, 2);
    check("eos_w0", {16'd0, rd_q[0]}, 32'h5A5A);
    check("eos_w1", {16'd0, rd_q[1]}, 32'hA5A5);
    check("eos_ready", {31'd0, ready}, 32'd0);

    // last4 on first transfer, then armed two words later.
    write_burst(22'h000, 6, 16'h0100, 16'h0001);
    read_burst(22'h000, 10, 0, got, lat);
    check("l4_first_count", got, 4);
    check("l4_first_w3", {16'd0, rd_q[3]}, 32'h0103);
    read_burst(22'h000, 10, 2, got, lat);
    check("l4_late_count", got, 6);
    check("l4_late_w5", {16'd0, rd_q[5]}, 32'h0105);

    // Request dropped during WAIT: ready never rises.
    request = 1'b1; write_enable = 1'b0; address = 22'h010;
    tick();
    request = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | ready;
    end
    check("wait_abort_ready", {31'd0, seen}, 32'd0);

    // Reset on the second write-data cycle.
    write_burst(22'h020, 2, 16'hEEEE, 16'h0000);
    request = 1'b1; write_enable = 1'b1; address = 22'h020;
    wait_ready(lat);
    data_write = 16'h0000; tick();
    data_write = 16'h7777; tick();
    data_write = 16'h8888; reset = 1'b1; tick();
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_data_read", {16'd0, data_read}, 32'h0);
    reset = 1'b0; request = 1'b0; write_enable = 1'b0;
    tick();
    read_burst(22'h020, 2, 99, got, lat);
    check("rst_mid_count", got, 2);
    check("rst_mid_w0", {16'd0, rd_q[0]}, 32'h7777);
    check("rst_mid_w1", {16'd0, rd_q[1]}, 32'hEEEE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
